// File: rtl/display_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the bitboard display arbiter.
package numbat_display_pkg;

    localparam int BOARD_BITS             = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Legacy-compatible state codes; the enum below is built on them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        ACK   = ST_ACK
    } arb_state_t;

    // Width of a requester index; never below one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle of requester and display-unit signals around the arbiter.
// Handshake: a requester holds req_valid (and its bitboard until granted) until
// it sees its 1-cycle req_ack, and drops req_valid in that ack cycle. Toward the
// display unit, disp_attacking_valid is a single-cycle start pulse with
// disp_attacking held stable until the ack; disp_done is a single-cycle
// completion pulse that only counts while the arbiter is waiting for it.
interface display_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import numbat_display_pkg::*;

    localparam int GW = idx_bits(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [BOARD_BITS*NUM_REQ-1:0] req_bitboard;
    logic [NUM_REQ-1:0]            req_ack;
    logic [BOARD_BITS-1:0]         disp_attacking;
    logic                          disp_attacking_valid;
    logic                          disp_done;
    logic [GW-1:0]                 grant_id;
    logic                          busy;
    logic                          timeout_err;
    logic [1:0]                    state_dbg;

    // Arbiter side.
    modport master (
        input  req_valid, req_bitboard, disp_done,
        output req_ack, disp_attacking, disp_attacking_valid,
               grant_id, busy, timeout_err, state_dbg
    );

    // Environment side: requesters plus display unit.
    modport slave (
        output req_valid, req_bitboard, disp_done,
        input  req_ack, disp_attacking, disp_attacking_valid,
               grant_id, busy, timeout_err, state_dbg
    );

endinterface

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module display_rr_pick
    import numbat_display_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int GW = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      idx,
    output logic               found
);

    // Scan NUM_REQ candidates starting at ptr; the first hit wins.
    always_comb begin : scan
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = GW'(cand);
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one bitboard display unit between NUM_REQ
// requesters: latches the granted board, pulses start, waits for done (with a
// watchdog), then acks the requester.
module display_arbiter
    import numbat_display_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    display_arbiter_if.master bus
);

    localparam int GW  = idx_bits(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WDW-1:0]     WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0]     WD_ONE   = WDW'(1);
    localparam logic [GW-1:0]      IDX_LAST = GW'(NUM_REQ - 1);
    localparam logic [GW-1:0]      IDX_ONE  = GW'(1);
    localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

    arb_state_t            state;
    logic [GW-1:0]         ptr;
    logic [WDW-1:0]        wd;
    logic [GW-1:0]         grant_id;
    logic [BOARD_BITS-1:0] board_q;
    logic                  valid_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic                  err_q;

    logic [GW-1:0]         pick_idx;
    logic                  pick_found;

    display_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Arbitration FSM with bitboard latch, watchdog, ack pulse and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            wd       <= '0;
            grant_id <= '0;
            board_q  <= '0;
            valid_q  <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        board_q  <= bus.req_bitboard[int'(pick_idx)*BOARD_BITS +: BOARD_BITS];
                        valid_q  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    valid_q <= 1'b0;
                    wd      <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    wd <= wd + WD_ONE;
                    // Done takes priority over an expiring watchdog in the same cycle.
                    if (bus.disp_done) begin
                        ack_q <= ACK_ONE << grant_id;
                        state <= ACK;
                    end else if (wd == WD_LAST) begin
                        err_q <= 1'b1;
                        ack_q <= ACK_ONE << grant_id;
                        state <= ACK;
                    end
                end
                ACK: begin
                    ack_q <= '0;
                    ptr   <= (grant_id == IDX_LAST) ? '0 : grant_id + IDX_ONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack              = ack_q;
    assign bus.disp_attacking       = board_q;
    assign bus.disp_attacking_valid = valid_q;
    assign bus.grant_id             = grant_id;
    assign bus.busy                 = (state != IDLE);
    assign bus.timeout_err          = err_q;
    assign bus.state_dbg            = state;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: two requesters, 100-cycle watchdog.
module tb_display_arbiter;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    localparam logic [63:0] BOARD_S = 64'h0000_0000_0000_FF00;
    localparam logic [63:0] BOARD_A = 64'hA5A5_0000_1234_5678;
    localparam logic [63:0] BOARD_B = 64'h5A5A_FFFF_8765_4321;
    localparam logic [63:0] BOARD_C = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] BOARD_D = 64'h8000_0000_0000_0001;
    localparam logic [63:0] BOARD_E = 64'h00FF_00FF_00FF_00FF;

    display_arbiter_if #(.NUM_REQ(2)) bus ();

    display_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one print from IDLE: grant, issue, wait `delay` WAIT cycles,
    // then either answer done or let the watchdog expire.
    task automatic serve(input int id, input logic [63:0] board, input int delay,
                         input bit give_done, input bit mutate,
                         input logic [1:0] next_req, input logic exp_err);
        logic [1:0] exp_ack;
        exp_ack = 2'b01 << id;
        tick();
        check("issue_valid", 64'(bus.disp_attacking_valid), 64'd1);
        check("grant_id", 64'(bus.grant_id), 64'(id));
        check("issue_board", bus.disp_attacking, board);
        check("busy_issue", 64'(bus.busy), 64'd1);
        if (mutate) bus.req_bitboard[64*id +: 64] = ~board;
        tick();
        check("valid_cleared", 64'(bus.disp_attacking_valid), 64'd0);
        check("state_wait", 64'(bus.state_dbg), 64'd2);
        for (int k = 0; k < delay; k++) begin
            tick();
            check("hold_board", bus.disp_attacking, board);
            check("no_early_ack", 64'(bus.req_ack), 64'd0);
        end
        if (give_done) bus.disp_done = 1'b1;
        tick();
        bus.disp_done = 1'b0;
        check("ack", 64'(bus.req_ack), 64'(exp_ack));
        check("ack_board", bus.disp_attacking, board);
        check("timeout_err_ack", 64'(bus.timeout_err), 64'(exp_err));
        bus.req_valid = next_req;
        tick();
        check("ack_one_cycle", 64'(bus.req_ack), 64'd0);
        check("idle_after_ack", 64'(bus.busy), 64'd0);
        check("timeout_err_idle", 64'(bus.timeout_err), 64'(exp_err));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_bitboard = '0;
        bus.disp_done    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(bus.disp_attacking_valid), 64'd0);
        check("rst_board", bus.disp_attacking, 64'd0);
        check("rst_ack", 64'(bus.req_ack), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.timeout_err), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'd0);

        // Single request, done after a ~66-cycle print
        bus.req_bitboard[63:0] = BOARD_S;
        bus.req_valid = 2'b01;
        serve(0, BOARD_S, 65, 1'b1, 1'b0, 2'b00, 1'b0);

        // Reset in the middle of WAIT: everything drops at once, no ack
        bus.req_bitboard[127:64] = BOARD_C;
        bus.req_valid = 2'b10;
        tick();
        check("pre_rst_grant", 64'(bus.grant_id), 64'd1);
        tick();
        tick();
        tick();
        check("pre_rst_wait", 64'(bus.state_dbg), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 64'(bus.disp_attacking_valid), 64'd0);
        check("async_board", bus.disp_attacking, 64'd0);
        check("async_grant", 64'(bus.grant_id), 64'd0);
        check("async_busy", 64'(bus.busy), 64'd0);
        check("async_ack", 64'(bus.req_ack), 64'd0);
        check("async_state", 64'(bus.state_dbg), 64'd0);
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("post_rst_no_ack", 64'(bus.req_ack), 64'd0);
        check("post_rst_idle", 64'(bus.busy), 64'd0);

        // Contention from pointer 0: grants 0,1,0
        bus.req_bitboard[63:0]   = BOARD_A;
        bus.req_bitboard[127:64] = BOARD_B;
        bus.req_valid = 2'b11;
        serve(0, BOARD_A, 5, 1'b1, 1'b0, 2'b11, 1'b0);
        serve(1, BOARD_B, 4, 1'b1, 1'b0, 2'b11, 1'b0);
        serve(0, BOARD_A, 6, 1'b1, 1'b0, 2'b00, 1'b0);

        // Board changes after the grant; latched copy must hold
        bus.req_valid = 2'b01;
        serve(0, BOARD_A, 4, 1'b1, 1'b1, 2'b00, 1'b0);

        // Done pulse while idle is ignored
        bus.disp_done = 1'b1;
        tick();
        bus.disp_done = 1'b0;
        check("stray_done_ack", 64'(bus.req_ack), 64'd0);
        check("stray_done_idle", 64'(bus.busy), 64'd0);

        // Watchdog timeout, then a normal print with the error still set
        bus.req_bitboard[63:0]   = BOARD_D;
        bus.req_bitboard[127:64] = BOARD_E;
        bus.req_valid = 2'b01;
        serve(0, BOARD_D, 99, 1'b0, 1'b0, 2'b10, 1'b1);
        serve(1, BOARD_E, 3, 1'b1, 1'b0, 2'b00, 1'b1);

        // Fresh reset, then done lands on the last watchdog cycle
        reset = 1'b1;
        #1;
        check("err_cleared", 64'(bus.timeout_err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_valid = 2'b01;
        serve(0, BOARD_D, 99, 1'b1, 1'b0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
